// File: rtl/seq_div_4.sv
// seq_div_4: sequential restoring divider.
// Divides an unsigned DW-bit dividend by an unsigned VW-bit divisor and
// produces one quotient bit per clock. A zero divisor takes a one-cycle
// path that returns an all-ones quotient and flags dbz.
//
// Handshake: start is sampled only while idle (busy = 0). The edge that
// samples start = 1 is the accept edge. Operands are captured on that
// edge, and busy stays high until the result is registered. done is a
// single-cycle pulse that marks the cycle in which quotient, remainder
// and dbz first show the new result. start while busy is ignored.
module seq_div_4 #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          dbz
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DZ   = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] dvd_sr;   // captured dividend, consumed MSB first
  logic [VW-1:0] dsr;      // captured divisor
  logic [VW-1:0] prem;     // restored partial remainder, always < divisor
  logic [DW-2:0] quo_sr;   // quotient bits collected so far
  logic [CW-1:0] count;    // iterations completed

  // Working values for one restoring step. The shifted remainder is
  // VW+1 bits wide, so the compare against the divisor cannot overflow.
  logic [VW:0]   trial;
  logic          fits;
  logic [VW-1:0] next_prem;
  logic          last;

  // One restoring iteration: shift in the next dividend bit, then
  // subtract the divisor if it fits.
  always_comb begin
    trial     = {prem, dvd_sr[DW-1]};
    fits      = (trial >= {1'b0, dsr});
    next_prem = trial[VW-1:0];
    if (fits) begin
      next_prem = VW'(trial - {1'b0, dsr});
    end
    last      = (count == CW'(DW - 1));
  end

  // Control FSM with the datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dvd_sr    <= '0;
      dsr       <= '0;
      prem      <= '0;
      quo_sr    <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Capture on both paths. The zero-divisor path also needs the
            // dividend, and later input changes must not affect it.
            dvd_sr <= dividend;
            dsr    <= divisor;
            prem   <= '0;
            quo_sr <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= (divisor != '0) ? CALC : DZ;
          end
        end

        CALC: begin
          prem   <= next_prem;
          dvd_sr <= {dvd_sr[DW-2:0], 1'b0};
          quo_sr <= {quo_sr[DW-3:0], fits};
          count  <= count + 1'b1;
          if (last) begin
            quotient  <= {quo_sr, fits};
            remainder <= next_prem;
            dbz       <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        DZ: begin
          quotient  <= '1;
          remainder <= dvd_sr[VW-1:0];
          dbz       <= 1'b1;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_4.sv
// tb_seq_div_4: directed and randomized checks of seq_div_4 against an
// arithmetic reference model (integer / and %).
module tb_seq_div_4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       dbz;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected results in issue order: {quotient, remainder, dbz}.
  logic [12:0] exp_q[$];

  seq_div_4 #(.DW(8), .VW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain unsigned division, with the zero-divisor result.
  function automatic logic [12:0] model(input int a, input int b);
    logic [7:0] q;
    logic [3:0] r;
    if (b == 0) begin
      r = 4'(a % 16);
      return {8'hFF, r, 1'b1};
    end
    q = 8'(a / b);
    r = 4'(a % b);
    return {q, r, 1'b0};
  endfunction

  // Drive one start pulse. On return the accept edge has passed and
  // the bench is at the following falling edge.
  task automatic issue(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    check("busy_rise", busy, 1'b1);
  endtask

  // Wait for done. Start at a falling edge and count rising edges until
  // done is seen. Then score the result against the expected queue.
  task automatic wait_done(input string tag, input int exp_lat, input bit pulse_chk);
    int          n;
    logic [12:0] e;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_busy"}, busy, 1'b0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h0;
    check({tag, "_q"},   quotient,  e[12:5]);
    check({tag, "_r"},   remainder, e[4:1]);
    check({tag, "_dbz"}, dbz,       e[0]);
    if (pulse_chk) begin
      @(negedge clk);
      check({tag, "_pulse"}, done, 1'b0);
    end
  endtask

  task automatic do_div(input string tag, input logic [7:0] a, input logic [3:0] b);
    issue(a, b);
    wait_done(tag, (b == 0) ? 1 : 8, 1'b1);
  endtask

  initial begin
    int ndone;
    int a;
    int b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_q",    quotient,  8'd0);
    check("rst_r",    remainder, 4'd0);
    check("rst_busy", busy,      1'b0);
    check("rst_done", done,      1'b0);
    check("rst_dbz",  dbz,       1'b0);
    rst = 1'b0;

    // basic divisions
    do_div("d12_4",  8'd12,  4'd4);
    do_div("d37_5",  8'd37,  4'd5);
    do_div("d200_7", 8'd200, 4'd7);

    // multiplier inverse and extremes
    do_div("d225_15", 8'd225, 4'd15);
    do_div("d255_1",  8'd255, 4'd1);
    do_div("d0_14",   8'd0,   4'd14);
    do_div("d14_15",  8'd14,  4'd15);

    // divide by zero, then a normal division
    do_div("dz9",   8'd9,  4'd0);
    do_div("d36_4", 8'd36, 4'd4);

    // start while busy is ignored
    issue(8'd100, 4'd3);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd50;
    divisor  = 4'd5;
    @(negedge clk);
    start    = 1'b0;
    wait_done("ign", 4, 1'b1);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ign_extra_done", ndone, 0);

    // back-to-back with start held high
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd12;
    divisor  = 4'd4;
    exp_q.push_back(model(12, 4));
    @(negedge clk);
    wait_done("b2b_1", 8, 1'b0);
    dividend = 8'd37;
    divisor  = 4'd5;
    exp_q.push_back(model(37, 5));
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    check("b2b_busy", busy, 1'b1);
    wait_done("b2b_2", 8, 1'b1);

    // reset in the middle of a division
    issue(8'd200, 4'd7);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("mrst_q",    quotient,  8'd0);
    check("mrst_r",    remainder, 4'd0);
    check("mrst_busy", busy,      1'b0);
    check("mrst_done", done,      1'b0);
    check("mrst_dbz",  dbz,       1'b0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mrst_no_done", ndone, 0);
    do_div("post_rst", 8'd37, 4'd5);

    // randomized divisions, some with a zero divisor
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_div("rnd", 8'(a), 4'(b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_div_4.md
# seq_div_4

Sequential restoring divider: the inverse companion to the team's shift-add sequential 4x4 multiplier. It divides an 8-bit dividend by a 4-bit divisor, one quotient bit per clock, and returns an 8-bit quotient and a 4-bit remainder with a start/busy/done handshake. It sits beside the multiplier core inside the Tiny Tapeout top level and is driven from the same `ui_in` / `uio_in` style operand and start pins. Recovering a multiplier product (for example 225 / 15 = 15) is its primary self-check use.

## Interface

Parameters:
- `DW`, 8: dividend and quotient width.
- `VW`, 4: divisor and remainder width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  DW  numerator; captured on the accept edge.
- `divisor`  in  VW  denominator; captured on the accept edge.
- `quotient`  out  DW  result quotient; holds until the next result.
- `remainder`  out  VW  result remainder; holds until the next result.
- `busy`  out  1  high while a division is in progress.
- `done`  out  1  one-cycle pulse when `quotient` and `remainder` are valid and newly updated.
- `dbz`  out  1  divide-by-zero flag for the last result; updates together with `done`.

## Operation

States:
- IDLE: `busy` = 0.
  - `start` = 1 with `divisor` != 0: capture operands, clear the partial remainder (VW+1 bits) and the iteration counter, go to CALC.
  - `start` = 1 with `divisor` = 0: go to DZ.
  - `start` = 0: stay in IDLE.
- CALC: one restoring iteration per cycle.
  - Step 1: shift {partial remainder, dividend shift reg} left by 1; the dividend MSB enters the partial remainder LSB.
  - Step 2: if partial remainder >= {1'b0, divisor}, subtract the divisor and shift 1 into the quotient reg; else shift 0.
  - After DW iterations: load `quotient` and `remainder[VW-1:0]`, set `dbz` = 0, pulse `done`, return to IDLE.
- DZ: single cycle.
  - Load `quotient` = all ones (8'hFF), `remainder` = `dividend[VW-1:0]`, `dbz` = 1.
  - Pulse `done` and return to IDLE.

Rules:
- Arithmetic is unsigned.
- Invariant: `quotient` * `divisor` + `remainder` == `dividend`; `remainder` < `divisor`.
- The partial remainder is VW+1 bits wide so the comparison never overflows.
- `start` while `busy` = 1 is ignored. No queuing, no effect on the captured operands.
- Input changes after the accept edge do not affect the result.
- Outputs `quotient`, `remainder` and `dbz` change only on the edge that raises `done`.

## Timing

Reset (`rst` high at a rising edge):
- State goes to IDLE; `quotient` = 0, `remainder` = 0, `busy` = 0, `done` = 0, `dbz` = 0; the counter clears.
- Reset mid-CALC aborts the division; no `done` pulse follows.
- Reset wins over a simultaneous `start`.

Latency, with accept edge E0:
- `busy` rises after E0.
- Iterations occur on E1..EDW (E1..E8 at default).
- At EDW the results are registered, `done` = 1 and `busy` = 0 for the cycle after EDW.
- Latency from accept to `done` is DW cycles (8).

Divide by zero:
- `busy` = 1 for exactly one cycle after E0.
- `done` and `dbz` become valid after E1.

Back-to-back and ordering:
- `start` held high during the `done` cycle is accepted at the next edge.
- Minimum issue interval is DW+1 cycles (9) for normal divisions and 2 for divide-by-zero.
- `done` is never high in two consecutive cycles.
- `done` never coincides with `busy` = 1.

## Test plan

1. Basic divisions, each with a 1-cycle `start` pulse and a wait for `done`:
   - 12 / 4 -> q=3, r=0, dbz=0.
   - 37 / 5 -> q=7, r=2.
   - 200 / 7 -> q=28, r=4.
   - `done` must arrive exactly 8 cycles after the accept edge.
2. Multiplier inverse and extremes:
   - 225 / 15 -> q=15, r=0.
   - 255 / 1 -> q=255, r=0.
   - 0 / 14 -> q=0, r=0.
   - 14 / 15 -> q=0, r=14.
3. Divide by zero: 9 / 0 -> `done` 1 cycle after accept, q=8'hFF, r=9, dbz=1. A following 36 / 4 -> q=9, r=0, dbz=0.
4. Start while busy: start 100 / 3, then pulse `start` with 50 / 5 at cycle 4 -> only q=33, r=1 is reported, with a single `done` pulse.
5. Back-to-back: hold `start` high continuously with 12 / 4 then switch to 37 / 5 in the `done` cycle -> second `done` exactly 9 cycles after the first, q=7, r=2.
6. Reset mid-operation: assert `rst` in cycle 5 of 200 / 7 -> all outputs 0 on the next cycle, no `done`. A subsequent 37 / 5 -> q=7, r=2.
